// File: rtl/tap_scan_ctrl.sv
// tap_scan_ctrl: tap-select sequencer that counts gated hits per tap and streams 4-byte result frames to a UART.
module tap_scan_ctrl #(
    parameter int N_TAPS     = 128,
    parameter int SEL_W      = 7,
    parameter int SETTLE_CYC = 4,
    parameter int GATE_CYC   = 1048576
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iCMD_DV,
    input  logic [7:0]       iCMD_BYTE,
    input  logic             iHIT,
    output logic [SEL_W-1:0] oSEL,
    output logic             oTX_DV,
    output logic [7:0]       oTX_BYTE,
    input  logic             iTX_DONE,
    output logic             oBUSY
);
    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_GATE, S_SEND, S_WAIT} state_t;

    localparam logic [23:0]      SETTLE_LAST = 24'(SETTLE_CYC - 1);
    localparam logic [23:0]      GATE_LAST   = 24'(GATE_CYC - 1);
    localparam logic [SEL_W-1:0] LAST_TAP    = SEL_W'(N_TAPS - 1);
    localparam logic [7:0]       N_TAPS_B    = 8'(N_TAPS);

    state_t           r_state;
    logic [SEL_W-1:0] r_sel;
    logic             r_tx_dv;
    logic [7:0]       r_tx_byte;
    logic [23:0]      r_cnt;
    logic [23:0]      r_hits;
    logic [1:0]       r_idx;
    logic             r_sweep;
    logic             r_end;
    logic             r_abort;

    logic       w_abort;
    logic       w_tap_ok;
    logic [7:0] w_next_byte;

    assign w_abort     = iCMD_DV && iCMD_BYTE == 8'hFF;
    assign w_tap_ok    = iCMD_BYTE < N_TAPS_B;
    // r_idx names the byte just sent; the next one is the following count slice
    assign w_next_byte = r_idx == 2'd0 ? r_hits[23:16] : r_idx == 2'd1 ? r_hits[15:8] : r_hits[7:0];

    assign oSEL     = r_sel;
    assign oTX_DV   = r_tx_dv;
    assign oTX_BYTE = r_tx_byte;
    assign oBUSY    = r_state != S_IDLE;

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_tx_dv   <= 1'b0;
            r_tx_byte <= '0;
            r_cnt     <= '0;
            r_hits    <= '0;
            r_idx     <= '0;
            r_sweep   <= 1'b0;
            r_end     <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_tx_dv <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (iCMD_DV && (w_tap_ok || iCMD_BYTE == 8'h80)) begin
                        r_sel   <= w_tap_ok ? iCMD_BYTE[SEL_W-1:0] : '0;
                        r_sweep <= !w_tap_ok;
                        r_cnt   <= '0;
                        r_end   <= 1'b0;
                        r_abort <= 1'b0;
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == SETTLE_LAST) begin
                        r_cnt   <= '0;
                        r_hits  <= '0;
                        r_state <= S_GATE;
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                end
                S_GATE: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (iHIT && r_hits != 24'hFFFFFF)
                            r_hits <= r_hits + 24'd1;
                        if (r_cnt == GATE_LAST) begin
                            r_idx     <= '0;
                            r_tx_dv   <= 1'b1;
                            r_tx_byte <= 8'(r_sel);
                            r_state   <= S_SEND;
                        end else begin
                            r_cnt <= r_cnt + 24'd1;
                        end
                    end
                end
                S_SEND: r_state <= w_abort ? S_IDLE : S_WAIT;
                S_WAIT: begin
                    // an in-flight byte always completes; abort only takes effect at its done
                    if (w_abort && !iTX_DONE) begin
                        r_abort <= 1'b1;
                    end else if (iTX_DONE) begin
                        if (w_abort || r_abort || r_end || (r_idx == 2'd3 && !r_sweep)) begin
                            r_state <= S_IDLE;
                        end else if (r_idx != 2'd3) begin
                            r_idx     <= r_idx + 2'd1;
                            r_tx_dv   <= 1'b1;
                            r_tx_byte <= w_next_byte;
                            r_state   <= S_SEND;
                        end else if (r_sel == LAST_TAP) begin
                            r_end     <= 1'b1;
                            r_tx_dv   <= 1'b1;
                            r_tx_byte <= 8'hFF;
                            r_state   <= S_SEND;
                        end else begin
                            r_sel   <= r_sel + SEL_W'(1);
                            r_cnt   <= '0;
                            r_state <= S_SETTLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tap_scan_ctrl.sv
// tb_tap_scan_ctrl: directed scenarios scored against a frame-level model of the measurement protocol.
module tb_tap_scan_ctrl;
    localparam int G = 16;

    logic       iCLK = 1'b0;
    logic       iRESET, iCMD_DV, iHIT, iTX_DONE;
    logic [7:0] iCMD_BYTE;
    logic [6:0] oSEL;
    logic       oTX_DV, oBUSY;
    logic [7:0] oTX_BYTE;

    tap_scan_ctrl #(.N_TAPS(128), .SEL_W(7), .SETTLE_CYC(4), .GATE_CYC(G)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iCMD_DV(iCMD_DV), .iCMD_BYTE(iCMD_BYTE),
        .iHIT(iHIT), .oSEL(oSEL), .oTX_DV(oTX_DV), .oTX_BYTE(oTX_BYTE),
        .iTX_DONE(iTX_DONE), .oBUSY(oBUSY)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;
    int hit_mode = 0, tx_lat = 2, tx_timer = 0;
    int done_cyc = -1, first_dv_cyc = -1, fall_cyc = -1, cmd_cyc = 0;
    logic [7:0] exp_q[$], rx_q[$];
    logic [6:0] sel_log[$];
    logic [7:0] last_byte = 8'h00;
    logic       prev_busy = 1'b0;
    logic [6:0] prev_sel = 7'h00;

    task automatic check(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
    endtask

    // hits seen over one gate window for each stimulus pattern
    function automatic int model_hits(input int mode, input int tap);
        return mode == 1 ? G : mode == 2 ? G / 2 : mode == 3 ? (tap % 2) * G : 0;
    endfunction

    task automatic push_frame(input int tap, input int h);
        exp_q.push_back(8'(tap));
        exp_q.push_back(8'(h >> 16));
        exp_q.push_back(8'(h >> 8));
        exp_q.push_back(8'(h));
    endtask

    function automatic int rxb(input int i);
        return i < rx_q.size() ? int'(rx_q[i]) : -1;
    endfunction

    initial begin
        iHIT = 1'b0;
        forever begin
            @(negedge iCLK);
            iHIT = hit_mode == 1 ? 1'b1 : hit_mode == 2 ? ~iHIT : hit_mode == 3 ? oSEL[0] : 1'b0;
        end
    end

    initial begin
        iTX_DONE = 1'b0;
        forever begin
            @(negedge iCLK);
            iTX_DONE = 1'b0;
            if (oTX_DV && !iRESET) begin
                tx_timer = tx_lat;
            end else if (tx_timer > 0) begin
                tx_timer--;
                if (tx_timer == 0) begin
                    iTX_DONE = 1'b1;
                    done_cyc = cyc;
                end
            end
        end
    end

    initial forever begin
        @(negedge iCLK);
        if (iRESET) begin
            last_byte = 8'h00;
            prev_busy = 1'b0;
        end else begin
            if (oTX_DV) begin
                rx_q.push_back(oTX_BYTE);
                if (first_dv_cyc < 0) first_dv_cyc = cyc;
                if (exp_q.size() == 0) check("unexpected_tx_strobe", 1, 0);
                else check("tx_byte", oTX_BYTE, exp_q.pop_front());
                last_byte = oTX_BYTE;
            end else begin
                check("tx_byte_hold", oTX_BYTE, last_byte);
            end
            if (prev_busy && !oBUSY) fall_cyc = cyc;
            prev_busy = oBUSY;
            if (oBUSY && oSEL != prev_sel) sel_log.push_back(oSEL);
            prev_sel = oSEL;
        end
    end

    task automatic cmd(input logic [7:0] b);
        @(negedge iCLK);
        iCMD_DV = 1'b1;
        iCMD_BYTE = b;
        cmd_cyc = cyc;
        @(negedge iCLK);
        iCMD_DV = 1'b0;
        iCMD_BYTE = 8'h00;
    endtask

    task automatic start();
        rx_q.delete();
        sel_log.delete();
        first_dv_cyc = -1;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        while (oBUSY && n < budget) begin
            @(negedge iCLK);
            n++;
        end
        check(nm, oBUSY, 0);
        check({nm, "_all_bytes_seen"}, exp_q.size(), 0);
    endtask

    task automatic wait_rx(input int cnt, input int budget, input string nm);
        int n = 0;
        while (rx_q.size() < cnt && n < budget) begin
            @(negedge iCLK);
            n++;
        end
        check(nm, rx_q.size(), cnt);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1);
    end

    initial begin
        iRESET = 1'b1;
        iCMD_DV = 1'b0;
        iCMD_BYTE = 8'h00;
        repeat (3) @(negedge iCLK);
        iRESET = 1'b0;
        @(negedge iCLK);
        check("rst_sel", oSEL, 0);
        check("rst_dv", oTX_DV, 0);
        check("rst_byte", oTX_BYTE, 0);
        check("rst_busy", oBUSY, 0);

        cmd(8'h81);
        check("ignored_0x81", oBUSY, 0);
        cmd(8'hFF);
        check("idle_abort_noop", oBUSY, 0);

        start();
        hit_mode = 1;
        tx_lat = 10;
        push_frame(5, model_hits(1, 5));
        cmd(8'h05);
        check("single_sel", oSEL, 5);
        check("single_busy", oBUSY, 1);
        wait_idle(300, "single_idle");
        check("single_first_dv_latency", first_dv_cyc - cmd_cyc, 21);
        check("single_busy_fall", fall_cyc, done_cyc + 1);
        check("single_nbytes", rx_q.size(), 4);
        check("single_b0", rxb(0), 8'h05);
        check("single_b3", rxb(3), 8'h10);

        start();
        hit_mode = 2;
        tx_lat = 3;
        push_frame(127, model_hits(2, 127));
        cmd(8'h7F);
        wait_idle(200, "half_idle");
        check("half_b0", rxb(0), 8'h7F);
        check("half_b3", rxb(3), 8'h08);

        start();
        hit_mode = 3;
        tx_lat = 1;
        for (int t = 0; t < 128; t++) push_frame(t, model_hits(3, t));
        exp_q.push_back(8'hFF);
        cmd(8'h80);
        wait_idle(10000, "sweep_idle");
        check("sweep_nbytes", rx_q.size(), 513);
        check("sweep_b4", rxb(4), 8'h01);
        check("sweep_b7", rxb(7), 8'h10);
        check("sweep_b11", rxb(11), 8'h00);
        check("sweep_last_count", rxb(511), 8'h10);
        check("sweep_end_marker", rxb(512), 8'hFF);
        check("sweep_nsel", sel_log.size(), 128);
        for (int i = 0; i < sel_log.size(); i++) check("sweep_sel_step", sel_log[i], i);

        start();
        hit_mode = 1;
        tx_lat = 2;
        push_frame(3, model_hits(1, 3));
        cmd(8'h03);
        repeat (6) @(negedge iCLK);
        cmd(8'h10);
        check("drop_sel_kept", oSEL, 3);
        wait_idle(200, "drop_idle");
        check("drop_b0", rxb(0), 8'h03);

        start();
        tx_lat = 5000;
        push_frame(1, model_hits(1, 1));
        cmd(8'h01);
        wait_idle(25000, "backpressure_idle");
        check("backpressure_nbytes", rx_q.size(), 4);

        start();
        tx_lat = 2;
        cmd(8'h02);
        repeat (8) @(negedge iCLK);
        cmd(8'hFF);
        check("abort_gate_busy", oBUSY, 0);
        repeat (40) @(negedge iCLK);
        check("abort_gate_nbytes", rx_q.size(), 0);

        start();
        tx_lat = 10;
        exp_q.push_back(8'h06);
        exp_q.push_back(8'h00);
        cmd(8'h06);
        wait_rx(2, 200, "abort_wait_reach_b2");
        repeat (3) @(negedge iCLK);
        cmd(8'hFF);
        wait_idle(100, "abort_wait_idle");
        check("abort_wait_busy_fall", fall_cyc, done_cyc + 1);
        repeat (30) @(negedge iCLK);
        check("abort_wait_nbytes", rx_q.size(), 2);

        start();
        tx_lat = 10;
        exp_q.push_back(8'h09);
        cmd(8'h09);
        wait_rx(1, 200, "abort_done_reach_b1");
        while (first_dv_cyc >= 0 && cyc < first_dv_cyc + 10) @(negedge iCLK);
        iCMD_DV = 1'b1;
        iCMD_BYTE = 8'hFF;
        cmd_cyc = cyc;
        @(negedge iCLK);
        iCMD_DV = 1'b0;
        iCMD_BYTE = 8'h00;
        check("abort_done_coincident", done_cyc, cmd_cyc);
        check("abort_done_busy", oBUSY, 0);
        repeat (30) @(negedge iCLK);
        check("abort_done_nbytes", rx_q.size(), 1);

        start();
        tx_lat = 2;
        cmd(8'h11);
        repeat (8) @(negedge iCLK);
        iRESET = 1'b1;
        #1;
        check("midrst_sel", oSEL, 0);
        check("midrst_dv", oTX_DV, 0);
        check("midrst_byte", oTX_BYTE, 0);
        check("midrst_busy", oBUSY, 0);
        repeat (2) @(negedge iCLK);
        iRESET = 1'b0;
        repeat (40) @(negedge iCLK);
        check("midrst_nbytes", rx_q.size(), 0);
        check("midrst_busy_after", oBUSY, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
